// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - start/busy/done operand and result bundle for serial_sub; ovf present under SERIAL_SUB_OVF_EN
interface serial_sub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, b_in,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  busy, done, d, b_out
    );

    modport slave (
        input  start, a, b, b_in,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output busy, done, d, b_out
    );
endinterface

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial subtractor d = a - b - b_in, LSB first; optional ovf port under SERIAL_SUB_OVF_EN
module serial_sub #(
    parameter int WIDTH = 4
) (
    input logic        clk,
    input logic        rst,
    serial_sub_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt;
    logic             bor;
    logic             bor_next;
    logic             b_out_q;
    logic             diff;
    logic             accept;
    logic             last;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
    logic             ovf_q;
`endif

    // Operands shift right so the active bit is always at index 0.
    always_comb begin
        accept     = 1'b0;
        state_next = state;
        last       = (cnt == CW'(WIDTH - 1));
        diff       = a_sh[0] ^ b_sh[0] ^ bor;
        bor_next   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bor);
        sr_next    = sr >> 1;
        sr_next[WIDTH-1] = diff;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bor     <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            sr      <= '0;
            d_q     <= '0;
            b_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                a_sh  <= bus.a;
                b_sh  <= bus.b;
                bor   <= bus.b_in;
                cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                a_msb <= bus.a[WIDTH-1];
                b_msb <= bus.b[WIDTH-1];
`endif
            end else if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                bor  <= bor_next;
                sr   <= sr_next;
                cnt  <= cnt + CW'(1);
                // Ports only change on the final bit; the shift register stays internal.
                if (last) begin
                    d_q     <= sr_next;
                    b_out_q <= bor_next;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_q   <= (WIDTH > 1) ? ((a_msb ^ b_msb) & (diff ^ a_msb)) : 1'b0;
`endif
                end
            end
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.d     = d_q;
    assign bus.b_out = b_out_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking bench for serial_sub against an arithmetic reference model
module tb_serial_sub;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    logic [W-1:0] cur_d;
    logic         cur_bo;
    logic         cur_ov;

    serial_sub_if #(.WIDTH(W)) sif ();

    serial_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int av, input int bv, input int bi,
                                  output logic [W-1:0] md, output logic mbo, output logic mov);
        int diff;
        int sa;
        int sb;
        int sd;
        diff = av - bv - bi;
        md   = W'((diff + (1 << W)) % (1 << W));
        mbo  = (diff < 0);
        sa   = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
        sb   = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
        sd   = sa - sb - bi;
        mov  = (W > 1) && ((sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1));
    endfunction

    task automatic scramble();
        sif.a    = W'($urandom);
        sif.b    = W'($urandom);
        sif.b_in = 1'($urandom);
    endtask

    // Called at a negedge; start is sampled at the following edge.
    task automatic launch(input int av, input int bv, input int bi);
        sif.start = 1'b1;
        sif.a     = W'(av);
        sif.b     = W'(bv);
        sif.b_in  = 1'(bi);
        @(negedge clk);
        sif.start = 1'b0;
        scramble();
    endtask

    task automatic finish_op(input string tag, input int av, input int bv, input int bi, input int lat0);
        logic [W-1:0] md;
        logic         mbo;
        logic         mov;
        int           lat;
        model(av, bv, bi, md, mbo, mov);
        lat = lat0;
        while (sif.done !== 1'b1 && lat < 3 * W) begin
            check({tag, "_busy"}, 32'(sif.busy), 32'd1);
            check({tag, "_hold_d"}, 32'(sif.d), 32'(cur_d));
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(W));
        check({tag, "_busy_at_done"}, 32'(sif.busy), 32'd0);
        check({tag, "_d"}, 32'(sif.d), 32'(md));
        check({tag, "_b_out"}, 32'(sif.b_out), 32'(mbo));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, 32'(sif.ovf), 32'(mov));
`endif
        cur_d  = md;
        cur_bo = mbo;
        cur_ov = mov;
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(sif.done), 32'd0);
        check({tag, "_idle_busy"}, 32'(sif.busy), 32'd0);
        check({tag, "_held_d"}, 32'(sif.d), 32'(cur_d));
        check({tag, "_held_b_out"}, 32'(sif.b_out), 32'(cur_bo));
    endtask

    initial begin
        int dn;
        n_assert  = 0;
        n_fail    = 0;
        cur_d     = '0;
        cur_bo    = 1'b0;
        cur_ov    = 1'b0;
        rst       = 1'b1;
        sif.start = 1'b0;
        scramble();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 32'(sif.busy), 32'd0);
        check("reset_done", 32'(sif.done), 32'd0);
        check("reset_d", 32'(sif.d), 32'd0);
        check("reset_b_out", 32'(sif.b_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", 32'(sif.ovf), 32'd0);
`endif
        @(negedge clk);
        check("idle_no_start", 32'(sif.busy), 32'd0);

        launch(0, 2, 1);
        finish_op("case1", 0, 2, 1, 0);
        after_done("case1");

        launch(5, 3, 0);
        finish_op("case2", 5, 3, 0, 0);
        after_done("case2");

        launch(8, 6, 0);
        finish_op("case3", 8, 6, 0, 0);
        after_done("case3");

        launch(9, 8, 1);
        finish_op("case4", 9, 8, 1, 0);
        launch(0, 0, 1);
        finish_op("case4_b2b", 0, 0, 1, 0);
        after_done("case4_b2b");

        // Start pulsed mid-run with different operands must be ignored.
        launch(5, 3, 0);
        check("case5_busy0", 32'(sif.busy), 32'd1);
        @(negedge clk);
        sif.start = 1'b1;
        sif.a     = 4'hf;
        sif.b     = 4'h0;
        sif.b_in  = 1'b0;
        @(negedge clk);
        sif.start = 1'b0;
        finish_op("case5", 5, 3, 0, 2);
        after_done("case5");

        launch(0, 2, 1);
        @(negedge clk);
        check("case6_running", 32'(sif.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("case6_rst_busy", 32'(sif.busy), 32'd0);
        check("case6_rst_done", 32'(sif.done), 32'd0);
        check("case6_rst_d", 32'(sif.d), 32'd0);
        check("case6_rst_b_out", 32'(sif.b_out), 32'd0);
        cur_d  = '0;
        cur_bo = 1'b0;
        cur_ov = 1'b0;
        dn = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (sif.done === 1'b1) dn++;
        end
        check("case6_no_done", 32'(dn), 32'd0);
        launch(0, 2, 1);
        finish_op("case6_restart", 0, 2, 1, 0);
        after_done("case6_restart");

        for (int k = 0; k < 24; k++) begin
            int av;
            int bv;
            int bi;
            av = int'($urandom_range((1 << W) - 1, 0));
            bv = int'($urandom_range((1 << W) - 1, 0));
            bi = int'($urandom_range(1, 0));
            launch(av, bv, bi);
            finish_op("rand", av, bv, bi, 0);
            if (k % 3 == 0) after_done("rand");
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
